// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a one-deep registered response slot per requester.
module alu_arbiter #(
    parameter int              DATA_W  = 32,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] ALU_ADD = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,

    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,

    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i
);

    logic              last_q;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              vld0_p1;
    logic              vld1_p1;
    logic [DATA_W-1:0] res0_p1;
    logic [DATA_W-1:0] res1_p1;

    // A full slot can take a new result in the same cycle it is being drained.
    assign elig0 = req0_valid_i & (~vld0_p1 | rsp0_ready_i);
    assign elig1 = req1_valid_i & (~vld1_p1 | rsp1_ready_i);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i) begin
            if (elig0 && elig1) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        alu_op_o = ALU_ADD;
        alu_a_o  = '0;
        alu_b_o  = '0;
        if (grant0) begin
            alu_op_o = req0_op_i;
            alu_a_o  = req0_a_i;
            alu_b_o  = req0_b_i;
        end else if (grant1) begin
            alu_op_o = req1_op_i;
            alu_a_o  = req1_a_i;
            alu_b_o  = req1_b_i;
        end
    end

    // Stage p0 -> p1: capture the ALU result into the granted requester's slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= 1'b1;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
            res0_p1 <= '0;
            res1_p1 <= '0;
        end else begin
            if (grant0) begin
                last_q <= 1'b0;
            end else if (grant1) begin
                last_q <= 1'b1;
            end

            if (grant0) begin
                vld0_p1 <= 1'b1;
                res0_p1 <= alu_result_i;
            end else if (rsp0_ready_i) begin
                vld0_p1 <= 1'b0;
            end

            if (grant1) begin
                vld1_p1 <= 1'b1;
                res1_p1 <= alu_result_i;
            end else if (rsp1_ready_i) begin
                vld1_p1 <= 1'b0;
            end
        end
    end

    assign rsp0_valid_o  = vld0_p1;
    assign rsp1_valid_o  = vld1_p1;
    assign rsp0_result_o = res0_p1;
    assign rsp1_result_o = res1_p1;

endmodule
